// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
//   state_t         : FSM encoding (IDLE -> MEM -> RESP -> IDLE)
//   XLEN_DEFAULT    : default data/address width
//   TIMEOUT_DEFAULT : default maximum number of cycles spent waiting for dmem_ack
package mem_stage_pkg;

  localparam int XLEN_DEFAULT    = 64;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/memory_stage.sv
// Memory stage of an in-order pipeline. It accepts one execute result at a
// time, optionally performs a single doubleword data-memory access, and
// presents the writeback payload until the writeback side takes it.
//
// Ports
//   clk, reset                      : clock, synchronous active-high reset
//   in_valid / in_ready             : execute -> memory handshake
//   ALUResult, WriteData, RdIn      : address or ALU result, store data, rd
//   MemRead, MemWrite, MemtoReg,
//   RegWrite                        : forwarded control
//   dmem_req, dmem_we, dmem_addr,
//   dmem_wdata                      : data memory request (held until ack)
//   dmem_ack, dmem_rdata            : data memory response
//   wb_valid / wb_ready             : memory -> writeback handshake
//   WBData, RdOut, RegWriteOut, err : writeback payload
//   dbg_state                       : current FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload unchanged until that
// edge; ready may be asserted independently of valid.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int XLEN    = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  input  logic [4:0]      RdIn,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] WBData,
  output logic [4:0]      RdOut,
  output logic            RegWriteOut,
  output logic            err,
  output state_t          dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             memtoreg_q;
  logic             regwrite_q;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      WBData      <= '0;
      RdOut       <= '0;
      RegWriteOut <= 1'b0;
      err         <= 1'b0;
      wait_cnt    <= '0;
      memtoreg_q  <= 1'b0;
      regwrite_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready   <= 1'b0;
            RdOut      <= RdIn;
            memtoreg_q <= MemtoReg;
            regwrite_q <= RegWrite;
            wait_cnt   <= '0;
            if (!MemRead && !MemWrite) begin
              // Pure ALU op: result goes straight to writeback.
              state       <= ST_RESP;
              wb_valid    <= 1'b1;
              WBData      <= ALUResult;
              err         <= 1'b0;
              RegWriteOut <= RegWrite;
            end else if ((MemRead && MemWrite) || (ALUResult[2:0] != 3'b000)) begin
              // Illegal combination or misaligned doubleword: never touch memory.
              state       <= ST_RESP;
              wb_valid    <= 1'b1;
              WBData      <= ALUResult;
              err         <= 1'b1;
              RegWriteOut <= 1'b0;
            end else begin
              state      <= ST_MEM;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= ALUResult;
              dmem_wdata <= WriteData;
            end
          end
        end

        ST_MEM: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (dmem_ack) begin
            state       <= ST_RESP;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            wb_valid    <= 1'b1;
            WBData      <= memtoreg_q ? dmem_rdata : dmem_addr;
            err         <= 1'b0;
            RegWriteOut <= regwrite_q;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= ST_RESP;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            wb_valid    <= 1'b1;
            WBData      <= dmem_addr;
            err         <= 1'b1;
            RegWriteOut <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          // Payload registers are left untouched here so they stay stable.
          if (wb_ready) begin
            state    <= ST_IDLE;
            wb_valid <= 1'b0;
            in_ready <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT SHALL default to 255 and set the maximum dmem_ack wait in cycles.
REQ-002 Parameter XLEN SHALL default to 64 and set the data/address width.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on rising edge only.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: execute result present.
REQ-006 Port in_ready, output, 1: stage can accept.
REQ-007 Port ALUResult, input, XLEN: address for loads/stores, or result for ALU ops.
REQ-008 Port WriteData, input, XLEN: store data.
REQ-009 Port RdIn, input, 5: destination register.
REQ-010 Ports MemRead, MemWrite, MemtoReg, RegWrite, input, 1 each: forwarded control.
REQ-011 Ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, XLEN), dmem_wdata (output, XLEN): data memory request.
REQ-012 Ports dmem_ack (input, 1), dmem_rdata (input, XLEN): data memory response.
REQ-013 Ports wb_valid (output, 1) and wb_ready (input, 1): writeback handshake.
REQ-014 Ports WBData (output, XLEN), RdOut (output, 5), RegWriteOut (output, 1), err (output, 1): writeback payload.

Function
REQ-015 FSM states SHALL be IDLE, MEM and RESP; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1; all inputs latched that edge.
REQ-017 Accept with MemRead=MemWrite=0: next state RESP, WBData=ALUResult, err=0.
REQ-018 Accept with exactly one of MemRead/MemWrite and ALUResult[2:0]=0: next state MEM.
REQ-019 Accept with ALUResult[2:0]!=0 on a memory op, or with MemRead=MemWrite=1: next state RESP, err=1, RegWriteOut=0, no dmem_req issued.
REQ-020 In MEM, dmem_req SHALL be 1; dmem_we=MemWrite, dmem_addr=ALUResult, and dmem_wdata=WriteData SHALL stay stable until ack.
REQ-021 dmem_ack=1 in MEM: capture dmem_rdata, go RESP; dmem_req SHALL be 0 next cycle.
REQ-022 dmem_ack in IDLE or RESP SHALL be ignored.
REQ-023 Wait counter SHALL clear on MEM entry and increment each MEM cycle without ack; reaching TIMEOUT goes RESP with err=1, RegWriteOut=0, and req dropped.
REQ-024 WBData SHALL be captured rdata when MemtoReg=1 and no error, else latched ALUResult.
REQ-025 RegWriteOut SHALL be latched RegWrite unless err=1; RdOut SHALL be latched RdIn.
REQ-026 In RESP, wb_valid=1 and payload SHALL hold stable until wb_ready=1, then go IDLE.
REQ-027 Latency: non-memory op accepted at edge N gives wb_valid from N+1; memory op gives dmem_req from N+1 and wb_valid one cycle after the ack edge.
REQ-028 Throughput: at most one op in flight; the earliest next accept SHALL be the cycle after the wb handshake.

Reset
REQ-029 Reset SHALL force IDLE with in_ready=1, dmem_req=0, dmem_we=0, wb_valid=0, err=0, RegWriteOut=0, and WBData/RdOut/dmem_addr/dmem_wdata/counter=0.
REQ-030 Reset mid-MEM or mid-RESP SHALL abandon the op; dmem_req and wb_valid SHALL be low the cycle after the reset edge; no late ack is captured.

Structure
REQ-031 Package mem_stage_pkg SHALL hold the state enum, XLEN and TIMEOUT defaults.
REQ-032 Single FSM module; no sub-module needed.

Verification
REQ-033 ALUResult=0x8, Rd=1, RegWrite=1, no mem -> wb_valid next cycle, WBData=0x8, RdOut=1, RegWriteOut=1.
REQ-034 LD addr 0x108, Rd=13, ack after 3 cycles with rdata=0xDEADBEEFDEADBEEF -> req held 3 cycles with addr stable, then WBData=0xDEADBEEFDEADBEEF, RdOut=13.
REQ-035 SD addr 0x110, wdata=0xDEADBEEFDEADBEEF, ack after 1 cycle -> dmem_we=1 and wdata matches, then wb_valid=1, RegWriteOut=0, err=0.
REQ-036 LD addr 0x10C -> no dmem_req, wb_valid next cycle with err=1 and RegWriteOut=0.
REQ-037 LD with no ack -> req high for exactly TIMEOUT cycles, then err=1; wb_ready held low 5 cycles -> payload stable, in_ready=0.
REQ-038 Reset on 2nd MEM cycle, then ack -> all outputs at reset values, no wb_valid.
